// File: rtl/uart_serial_receiver.sv
// uart_serial_receiver: 16x-oversampled UART frame receiver with show-ahead error-flagged FIFO and rts throttle; define UART_SERIAL_RECEIVER_PARITY_EN to add the parity stage
module uart_serial_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_enable,
  input  logic                 parity_even,
  input  logic                 stop_bits2,
  output logic                 rts,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
  localparam int EW = DATA_BITS + 2;
`else
  localparam int EW = DATA_BITS + 1;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, sample, push, pop, full, wr, frm_err, frm_fin, cfg_sb2;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] word, head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
  logic cfg_pe, cfg_pev, par_err;
`else
  logic unused_cfg;
  assign unused_cfg = parity_enable ^ parity_even;
`endif
  assign sample  = baud_tick && tick_cnt == (state == START ? 4'd7 : 4'd15);
  assign frm_fin = frm_err | ~rx_s;
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
  assign word = {frm_fin, par_err, shift};
`else
  assign word = {frm_fin, shift};
`endif
  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE:  state_n = (baud_tick && !rx_s) ? START : IDLE;
      START: state_n = sample ? (rx_s ? IDLE : DATA) : START;
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
      DATA:   state_n = (sample && bit_cnt == 3'(DATA_BITS - 1)) ? (cfg_pe ? PARITY : STOP1) : DATA;
      PARITY: state_n = sample ? STOP1 : PARITY;
`else
      DATA:  state_n = (sample && bit_cnt == 3'(DATA_BITS - 1)) ? STOP1 : DATA;
`endif
      STOP1: begin
        push    = sample && !cfg_sb2;
        state_n = sample ? (cfg_sb2 ? STOP2 : (rx_s ? IDLE : BRK)) : STOP1;
      end
      STOP2: begin
        push    = sample;
        state_n = sample ? (rx_s ? IDLE : BRK) : STOP2;
      end
      BRK:     state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      frm_err  <= 1'b0;
      cfg_sb2  <= 1'b0;
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
      cfg_pe   <= 1'b0;
      cfg_pev  <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      tick_cnt <= (state == IDLE || (state == START && sample)) ? '0 : tick_cnt + 4'(baud_tick);
      if (state == IDLE && state_n == START) begin
        cfg_sb2 <= stop_bits2;
        frm_err <= 1'b0;
        bit_cnt <= '0;
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
        cfg_pe  <= parity_enable;
        cfg_pev <= parity_even;
        par_err <= 1'b0;
`endif
      end
      if (state == DATA && sample) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
      if (state == PARITY && sample)
        par_err <= rx_s != (cfg_pev ? ^shift : ~^shift);
`endif
      if (state == STOP1 && sample)
        frm_err <= ~rx_s;
    end
  end
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop  = data_valid & data_ready;
  assign wr   = push & (~full | pop);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= word;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
      rts     <= 1'b0;
    end else begin
      wp      <= wp + AW'(wr);
      rp      <= rp + AW'(pop);
      count   <= count + (AW+1)'(wr) - (AW+1)'(pop);
      overrun <= push & full & ~pop;
      rts     <= count < (AW+1)'(FIFO_DEPTH - 2);
    end
  end
  assign head          = mem[rp];
  assign data_valid    = count != '0;
  assign data_out      = data_valid ? head[DATA_BITS-1:0] : '0;
  assign framing_error = data_valid & head[EW-1];
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
  assign parity_error  = data_valid & head[DATA_BITS];
`else
  assign parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_serial_receiver.sv
// tb_uart_serial_receiver: randomized frame stimulus with a queued expected-word scoreboard and a decoupled pop monitor
module tb_uart_serial_receiver;
  localparam int TP = 2;
  localparam int BIT = 16 * TP;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1, baud_tick = 0, rx = 1;
  logic parity_enable = 0, parity_even = 0, stop_bits2 = 0, data_ready = 0;
  logic rts, parity_error, framing_error, data_valid, overrun;
  logic [7:0] data_out;
  int ncmp = 0, nerr = 0, ov_exp = 0, ov_seen = 0, ov_wide = 0, tc = 0;
  logic [9:0] exp_q[$];
  bit rnd = 0;
  logic ov_prev = 0;

  uart_serial_receiver #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
    .parity_enable(parity_enable), .parity_even(parity_even), .stop_bits2(stop_bits2),
    .rts(rts), .data_out(data_out), .parity_error(parity_error), .framing_error(framing_error),
    .data_valid(data_valid), .data_ready(data_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    baud_tick = (tc == 0);
    tc = (tc + 1) % TP;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rnd) data_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) step();
  endtask

  task automatic expect_word(input logic fe, input logic pe, input logic [7:0] d);
    if (exp_q.size() >= DEPTH) ov_exp++;
    else exp_q.push_back({fe, pe, d});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pev, input logic pbit,
                            input logic s1, input logic sb2, input logic s2, input int gap);
    logic has_par, bad_par, fe, last_low;
    int ones;
    parity_enable = pen;
    parity_even = pev;
    stop_bits2 = sb2;
    ones = $countones(d);
    bad_par = pbit != (pev ? (ones % 2 == 1) : (ones % 2 == 0));
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
    has_par = pen;
`else
    has_par = 0;
`endif
    fe = !s1 || (sb2 && !s2);
    last_low = sb2 ? !s2 : !s1;
    expect_word(fe, has_par && bad_par, d);
    hold(0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (has_par) hold(pbit, BIT);
    hold(s1, BIT);
    if (sb2) hold(s2, BIT);
    hold(1, ((last_low && gap == 0) ? 1 : gap) * BIT);
  endtask

  task automatic drain();
    rnd = 1;
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || data_valid); i++) step();
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", data_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rts"}, rts, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_perr"}, parity_error, 0);
    chk({tag, "_ferr"}, framing_error, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (overrun) begin
        ov_seen++;
        if (ov_prev) ov_wide++;
      end
      ov_prev = overrun;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_word: got %0h with no word expected", {framing_error, parity_error, data_out});
        end else chk("rx_word", {framing_error, parity_error, data_out}, exp_q.pop_front());
      end
    end else ov_prev = 0;
  end

  initial begin
    reset = 1;
    repeat (4) step();
    chk_reset_vals("reset");
    reset = 0;
    step(); step();
    chk("rts_after_reset", rts, 1);

    rnd = 0;
    data_ready = 0;
    send_frame(8'h55, 0, 0, 0, 1, 0, 1, 2);
    chk("hold_valid", data_valid, 1);
    chk("hold_data", data_out, 8'h55);
    chk("hold_ferr", framing_error, 0);
    chk("hold_perr", parity_error, 0);
    data_ready = 1;
    step();
    data_ready = 0;
    chk("pop_clears_valid", data_valid, 0);

    rx = 0;
    repeat (4 * TP) step();
    hold(1, 2 * BIT);
    chk("false_start_no_push", data_valid, 0);

    rnd = 1;
    send_frame(8'h81, 0, 0, 0, 1, 0, 1, 2);
    send_frame(8'hA3, 0, 0, 0, 0, 0, 1, 2);
    send_frame(8'h00, 0, 0, 0, 1, 0, 1, 2);
    parity_enable = 0;
    stop_bits2 = 0;
    expect_word(1, 0, 8'h00);
    hold(0, 14 * BIT);
    hold(1, 2 * BIT);
    send_frame(8'hC6, 0, 0, 0, 1, 1, 1, 1);
    send_frame(8'h3B, 0, 0, 0, 1, 1, 0, 1);
`ifdef UART_SERIAL_RECEIVER_PARITY_EN
    send_frame(8'h07, 1, 1, 0, 1, 0, 1, 2);
    send_frame(8'h07, 1, 1, 1, 1, 0, 1, 2);
    send_frame(8'h07, 1, 0, 1, 1, 0, 1, 2);
`endif
    drain();

    rnd = 0;
    data_ready = 0;
    for (int k = 0; k < 17; k++) begin
      send_frame(8'(k), 0, 0, 0, 1, 0, 1, 1);
      chk("rts_fill", rts, (k + 1) < 14);
    end
    chk("overrun_pulses", ov_seen, ov_exp);
    chk("overrun_width", ov_wide, 0);
    chk("full_valid", data_valid, 1);
    chk("full_head", data_out, 8'h00);
    drain();

    rnd = 0;
    data_ready = 0;
    send_frame(8'h5A, 0, 0, 0, 1, 0, 1, 1);
    hold(0, BIT);
    hold(1, 3 * BIT + BIT / 2);
    reset = 1;
    exp_q.delete();
    step(); step();
    chk_reset_vals("midframe_reset");
    reset = 0;
    step(); step();
    chk("rts_after_midframe", rts, 1);
    rnd = 1;
    send_frame(8'h3C, 0, 0, 0, 1, 0, 1, 2);
    drain();

    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) != 0), $urandom_range(0, 2));
    end
    drain();
    chk("overrun_total", ov_seen, ov_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
